// File: rtl/multicycle_controller.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb sequencing with
// memory handshake, wait timeout and a sticky error state.
module multicycle_controller #(
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 16,
    parameter int HALF_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               Jr,
    output logic               Jump,
    output logic               Jal,
    output logic               Extend_h,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               instr_done,
    output logic               err
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_ALU, C_BEQ, C_BNE, C_J, C_JAL,
        C_JR, C_JALR, C_LOAD, C_STORE
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        logic [3:0] alu;
        logic       half;
        logic       rtype;
    } dec_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t        cur, nxt;
    logic [CW-1:0] cnt;
    logic [5:0]    op_q, fn_q;
    dec_t          dq;
    logic          tmo;

    function automatic dec_t decode(input logic [5:0] op,
                                    input logic [5:0] fn);
        dec_t d;
        d = '0;
        d.cls = C_ILL;
        case (op)
            6'h00: begin
                d.rtype = 1'b1;
                d.cls   = C_ALU;
                case (fn)
                    6'h20:   d.alu = 4'd1;
                    6'h22:   d.alu = 4'd2;
                    6'h24:   d.alu = 4'd3;
                    6'h25:   d.alu = 4'd4;
                    6'h26:   d.alu = 4'd5;
                    6'h27:   d.alu = 4'd6;
                    6'h2a:   d.alu = 4'd7;
                    6'h00:   d.alu = 4'd8;
                    6'h02:   d.alu = 4'd9;
                    6'h08:   d.cls = C_JR;
                    6'h09:   d.cls = C_JALR;
                    default: d.cls = C_ILL;
                endcase
            end
            6'h08: begin d.cls = C_ALU;   d.alu = 4'd1;  end
            6'h0c: begin d.cls = C_ALU;   d.alu = 4'd3;  end
            6'h0a: begin d.cls = C_ALU;   d.alu = 4'd7;  end
            6'h04: begin d.cls = C_BEQ;   d.alu = 4'd10; end
            6'h05: begin d.cls = C_BNE;   d.alu = 4'd11; end
            6'h23: begin d.cls = C_LOAD;  d.alu = 4'd1;  end
            6'h2b: begin d.cls = C_STORE; d.alu = 4'd1;  end
            6'h02: d.cls = C_J;
            6'h03: d.cls = C_JAL;
            6'h21: if (HALF_EN != 0) begin
                d.cls  = C_LOAD;
                d.alu  = 4'd1;
                d.half = 1'b1;
            end
            6'h29: if (HALF_EN != 0) begin
                d.cls  = C_STORE;
                d.alu  = 4'd1;
                d.half = 1'b1;
            end
            default: d.cls = C_ILL;
        endcase
        return d;
    endfunction

    assign dq    = decode(op_q, fn_q);
    assign tmo   = (cnt == CW'(TIMEOUT - 1)) && !mem_ready;
    assign state = cur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur  <= FETCH;
            cnt  <= '0;
            op_q <= '0;
            fn_q <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                cnt <= '0;
            else if (!mem_ready && (cur == FETCH || cur == MEM))
                cnt <= cnt + CW'(1);
            if (cur == DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    // Every output is gated by rst so reset silences strobes immediately.
    always_comb begin
        nxt        = cur;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        Jr         = 1'b0;
        Jump       = 1'b0;
        Jal        = 1'b0;
        Extend_h   = 1'b0;
        ALUOp      = '0;
        instr_done = 1'b0;
        err        = 1'b0;
        if (rst) begin
            case (cur)
                FETCH: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        nxt     = DECODE;
                    end else if (tmo) begin
                        nxt = ERR;
                    end
                end
                DECODE: begin
                    if (decode(opcode, funct).cls == C_ILL)
                        nxt = ERR;
                    else
                        nxt = EXEC;
                end
                EXEC: begin
                    Extend_h = dq.half;
                    ALUOp    = ALUOP_W'(dq.alu);
                    nxt      = FETCH;
                    case (dq.cls)
                        C_ALU:   nxt = WB;
                        C_BEQ:   PCWrite = zero;
                        C_BNE:   PCWrite = !zero;
                        C_J: begin
                            Jump    = 1'b1;
                            PCWrite = 1'b1;
                        end
                        C_JAL: begin
                            Jump     = 1'b1;
                            Jal      = 1'b1;
                            RegWrite = 1'b1;
                            PCWrite  = 1'b1;
                        end
                        C_JR: begin
                            Jr      = 1'b1;
                            PCWrite = 1'b1;
                        end
                        C_JALR: begin
                            Jr       = 1'b1;
                            Jal      = 1'b1;
                            RegWrite = 1'b1;
                            PCWrite  = 1'b1;
                        end
                        C_LOAD, C_STORE: nxt = MEM;
                        default: nxt = ERR;
                    endcase
                end
                MEM: begin
                    Extend_h = dq.half;
                    MemRead  = (dq.cls == C_LOAD);
                    MemWrite = (dq.cls != C_LOAD);
                    if (mem_ready)
                        nxt = (dq.cls == C_LOAD) ? WB : FETCH;
                    else if (tmo)
                        nxt = ERR;
                end
                WB: begin
                    RegWrite = 1'b1;
                    RegDst   = dq.rtype;
                    MemtoReg = (dq.cls == C_LOAD);
                    Extend_h = dq.half;
                    nxt      = FETCH;
                end
                ERR: err = 1'b1;
                default: nxt = ERR;
            endcase
            instr_done = (cur != FETCH) && (nxt == FETCH);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: per-instruction expected cycle traces built from the
// instruction rules, replayed against a default and a small configuration.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [19:0] a_o, b_o;

    localparam logic [19:0] PCW  = 20'h00001;
    localparam logic [19:0] IRW  = 20'h00002;
    localparam logic [19:0] MRD  = 20'h00004;
    localparam logic [19:0] MWR  = 20'h00008;
    localparam logic [19:0] M2R  = 20'h00010;
    localparam logic [19:0] RW   = 20'h00020;
    localparam logic [19:0] RD   = 20'h00040;
    localparam logic [19:0] JRB  = 20'h00080;
    localparam logic [19:0] JMP  = 20'h00100;
    localparam logic [19:0] JALB = 20'h00200;
    localparam logic [19:0] EH   = 20'h00400;
    localparam logic [19:0] DONE = 20'h08000;
    localparam logic [19:0] ERRB = 20'h10000;

    localparam int K_ALU = 0, K_BEQ = 1, K_BNE = 2, K_J = 3, K_JAL = 4;
    localparam int K_JR = 5, K_JALR = 6, K_LD = 7, K_ST = 8, K_ILL = 9;
    localparam int N = 22;

    int t_op[N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    8, 12, 10, 4, 5, 35, 43, 2, 3, 33, 41};
    int t_fn[N] = '{32, 34, 36, 37, 38, 39, 42, 0, 2, 8, 9,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int t_alu[N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0,
                     1, 3, 7, 10, 11, 1, 1, 0, 0, 1, 1};
    int t_k[N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 6,
                   0, 0, 0, 1, 2, 7, 8, 3, 4, 7, 8};
    bit t_h[N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    typedef struct {
        logic        r;
        logic        m;
        logic        z;
        logic [5:0]  o;
        logic [5:0]  f;
        logic [19:0] e;
    } cyc_t;

    cyc_t q[$];
    cyc_t tmp[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   to_v = 16;
    bit   half_v = 1'b1;
    bit   sel = 1'b0;

    always #5 clk = ~clk;

    multicycle_controller u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(a_o[0]), .IRWrite(a_o[1]), .MemRead(a_o[2]),
        .MemWrite(a_o[3]), .MemtoReg(a_o[4]), .RegWrite(a_o[5]),
        .RegDst(a_o[6]), .Jr(a_o[7]), .Jump(a_o[8]), .Jal(a_o[9]),
        .Extend_h(a_o[10]), .ALUOp(a_o[14:11]),
        .instr_done(a_o[15]), .err(a_o[16]), .state(a_o[19:17])
    );

    multicycle_controller #(.ALUOP_W(4), .TIMEOUT(4), .HALF_EN(0)) u_small (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .PCWrite(b_o[0]), .IRWrite(b_o[1]), .MemRead(b_o[2]),
        .MemWrite(b_o[3]), .MemtoReg(b_o[4]), .RegWrite(b_o[5]),
        .RegDst(b_o[6]), .Jr(b_o[7]), .Jump(b_o[8]), .Jal(b_o[9]),
        .Extend_h(b_o[10]), .ALUOp(b_o[14:11]),
        .instr_done(b_o[15]), .err(b_o[16]), .state(b_o[19:17])
    );

    function automatic logic [19:0] st(input int s);
        return 20'(s) << 17;
    endfunction

    function automatic logic [19:0] alu(input int a);
        return 20'(a) << 11;
    endfunction

    function automatic int lookup(input logic [5:0] op, input logic [5:0] fn,
                                  input bit half);
        for (int i = 0; i < N; i++)
            if (t_op[i] == int'(op) && (op != 0 || t_fn[i] == int'(fn))
                && (!t_h[i] || half))
                return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [19:0] got,
                         input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input logic r, input logic m, input logic z,
                        input logic [5:0] o, input logic [5:0] f,
                        input logic [19:0] e);
        cyc_t c;
        c.r = r; c.m = m; c.z = z; c.o = o; c.f = f; c.e = e;
        tmp.push_back(c);
    endtask

    task automatic pm(input logic m, input logic [19:0] e);
        push(1'b1, m, 1'($urandom), 6'($urandom), 6'($urandom), e);
    endtask

    task automatic pr(input logic [19:0] e);
        pm(1'($urandom), e);
    endtask

    task automatic preset();
        push(1'b0, 1'($urandom), 1'($urandom), 6'($urandom),
             6'($urandom), 20'h0);
    endtask

    task automatic flush();
        while (tmp.size() > 0) q.push_back(tmp.pop_front());
    endtask

    task automatic gen(input logic [5:0] op, input logic [5:0] fn,
                       input int wf, input int wm, input logic z,
                       input int cut);
        int idx, k, a, nw;
        bit h, bad;
        logic [19:0] e, s;
        tmp.delete();
        idx = lookup(op, fn, half_v);
        k   = (idx < 0) ? K_ILL : t_k[idx];
        a   = (idx < 0) ? 0 : t_alu[idx];
        h   = (idx < 0) ? 1'b0 : t_h[idx];
        bad = 1'b0;
        nw  = (wf < to_v) ? wf : to_v;
        for (int i = 0; i < nw; i++) pm(1'b0, st(0) | MRD);
        if (wf >= to_v) bad = 1'b1;
        else pm(1'b1, st(0) | MRD | IRW | PCW);
        if (!bad) begin
            push(1'b1, 1'($urandom), 1'($urandom), op, fn, st(1));
            if (k == K_ILL) bad = 1'b1;
        end
        if (!bad) begin
            e = h ? EH : 20'h0;
            case (k)
                K_ALU: begin
                    pr(st(2) | alu(a));
                    pr(st(4) | RW | ((op == 0) ? RD : 20'h0) | DONE);
                end
                K_BEQ, K_BNE: begin
                    s = ((k == K_BEQ) == z) ? PCW : 20'h0;
                    push(1'b1, 1'($urandom), z, 6'($urandom), 6'($urandom),
                         st(2) | alu(a) | s | DONE);
                end
                K_J:    pr(st(2) | JMP | PCW | DONE);
                K_JAL:  pr(st(2) | JMP | JALB | RW | PCW | DONE);
                K_JR:   pr(st(2) | JRB | PCW | DONE);
                K_JALR: pr(st(2) | JRB | JALB | RW | PCW | DONE);
                default: begin
                    pr(st(2) | alu(1) | e);
                    s  = (k == K_LD) ? MRD : MWR;
                    nw = (wm < to_v) ? wm : to_v;
                    for (int i = 0; i < nw; i++) pm(1'b0, st(3) | s | e);
                    if (wm >= to_v) bad = 1'b1;
                    else if (k == K_LD) begin
                        pm(1'b1, st(3) | s | e);
                        pr(st(4) | RW | M2R | e | DONE);
                    end else pm(1'b1, st(3) | s | e | DONE);
                end
            endcase
        end
        if (bad) begin
            repeat (3) pr(st(5) | ERRB);
            preset();
        end
        if (cut >= 0 && cut < tmp.size()) begin
            while (tmp.size() > cut) void'(tmp.pop_back());
            preset();
        end
        flush();
    endtask

    task automatic wait_rand(output int w);
        w = ($urandom_range(0, 9) == 0) ? $urandom_range(0, to_v + 1)
                                        : $urandom_range(0, 3);
    endtask

    task automatic gen_rand(input int n);
        int idx, wf, wm, cut;
        logic [5:0] op, fn;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                idx = $urandom_range(0, N - 1);
                op  = 6'(t_op[idx]);
                fn  = (op == 0) ? 6'(t_fn[idx]) : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            wait_rand(wf);
            wait_rand(wm);
            cut = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1;
            gen(op, fn, wf, wm, 1'($urandom), cut);
        end
    endtask

    task automatic run_q(input string tag);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            rst       = c.r;
            mem_ready = c.m;
            zero      = c.z;
            opcode    = c.o;
            funct     = c.f;
            @(negedge clk);
            cyc++;
            check(tag, sel ? b_o : a_o, c.e);
        end
    endtask

    initial begin
        sel = 1'b0; to_v = 16; half_v = 1'b1;
        tmp.delete(); preset(); flush();
        gen(6'h00, 6'h20, 0, 0, 1'b0, -1);
        gen(6'h23, 6'h00, 0, 3, 1'b0, -1);
        gen(6'h04, 6'h00, 0, 0, 1'b1, -1);
        gen(6'h04, 6'h00, 0, 0, 1'b0, -1);
        gen(6'h21, 6'h00, 1, 1, 1'b0, -1);
        gen(6'h2b, 6'h00, 0, 2, 1'b0, 4);
        gen(6'h00, 6'h22, 0, 0, 1'b0, -1);
        gen(6'h00, 6'h20, 16, 0, 1'b0, -1);
        gen(6'h00, 6'h20, 15, 0, 1'b0, -1);
        gen_rand(300);
        run_q("dflt");

        sel = 1'b1; to_v = 4; half_v = 1'b0;
        tmp.delete(); preset(); flush();
        gen(6'h21, 6'h00, 0, 0, 1'b0, -1);
        gen(6'h00, 6'h20, 4, 0, 1'b0, -1);
        gen(6'h00, 6'h20, 3, 0, 1'b0, -1);
        gen(6'h23, 6'h00, 0, 4, 1'b0, -1);
        gen(6'h29, 6'h00, 0, 0, 1'b0, -1);
        gen_rand(150);
        run_q("small");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
